pipe_stage_skid: RTL and testbench

//  Generic elastic pipeline-stage register; replaces per-stage hand-written F/D/E/M/W regs.

---
 rtl/pipe_pkg.sv | 19 +
 rtl/pipe_stage_skid_sat_counter.sv | 28 ++
 rtl/pipe_stage_skid.sv | 144 ++++++++++++++
 tb/tb_pipe_stage_skid.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the elastic pipeline stage: occupancy states and a helper
// that maps a state to the number of live entries it holds.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_e;

    function automatic logic [1:0] live_entries(input stage_state_e s);
        case (s)
            ST_BUSY: return 2'd1;
            ST_FULL: return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating event counter: adds 0..2 per cycle, sticks at all-ones,
// synchronous clear.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [1:0]   inc,
    output logic [W-1:0] cnt
);

    logic [W:0] sum;

    always_comb begin
        sum = {1'b0, cnt} + (W+1)'(inc);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (sum[W]) begin
            cnt <= '1;
        end else begin
            cnt <= sum[W-1:0];
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic valid/ready pipeline register with optional 2-entry skid buffer,
// flush-to-bubble and saturating stall / flush-drop counters.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter int                SKID       = 1,
    parameter logic [DATA_W-1:0] RESET_DATA = '0,
    parameter logic [DATA_W-1:0] FLUSH_DATA = '1,
    parameter int                CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_drop_cnt
);

    stage_state_e      state;
    stage_state_e      state_nxt;
    logic [DATA_W-1:0] main_q;
    logic              in_fire;
    logic              out_fire;
    logic              load_main;
    logic              main_from_skid;
    logic              load_skid;
    logic [1:0]        stall_inc;
    logic [1:0]        drop_inc;

    assign out_data = main_q;

    always_comb begin
        out_valid = (state != ST_EMPTY);
        // Without a skid entry, readiness must look through to the consumer.
        if (SKID != 0) begin
            in_ready = !rst && (state != ST_FULL);
        end else begin
            in_ready = !rst && (!out_valid || out_ready);
        end
        in_fire  = in_valid && in_ready;
        out_fire = out_valid && out_ready;

        state_nxt      = state;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_nxt = ST_BUSY;
                    load_main = 1'b1;
                end
            end
            ST_BUSY: begin
                if (in_fire && out_fire) begin
                    load_main = 1'b1;
                end else if (in_fire) begin
                    state_nxt = ST_FULL;
                    load_skid = 1'b1;
                end else if (out_fire) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_fire) begin
                    state_nxt      = ST_BUSY;
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase

        stall_inc = {1'b0, out_valid && !out_ready && !flush};
        // An entry popped on the flush edge was delivered, so it is not a drop.
        drop_inc  = flush ? (live_entries(state) - {1'b0, out_fire}) : 2'd0;
    end

    generate
        if (SKID != 0) begin : g_skid
            logic [DATA_W-1:0] skid_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    state  <= ST_EMPTY;
                    main_q <= RESET_DATA;
                    skid_q <= RESET_DATA;
                end else if (flush) begin
                    state  <= ST_EMPTY;
                    main_q <= FLUSH_DATA;
                    skid_q <= FLUSH_DATA;
                end else begin
                    state <= state_nxt;
                    if (load_main) begin
                        main_q <= main_from_skid ? skid_q : in_data;
                    end
                    if (load_skid) begin
                        skid_q <= in_data;
                    end
                end
            end
        end else begin : g_single
            // FULL is unreachable here, so the skid controls never assert.
            logic unused_skid_ctl;
            assign unused_skid_ctl = load_skid ^ main_from_skid;

            always_ff @(posedge clk) begin
                if (rst) begin
                    state  <= ST_EMPTY;
                    main_q <= RESET_DATA;
                end else if (flush) begin
                    state  <= ST_EMPTY;
                    main_q <= FLUSH_DATA;
                end else begin
                    state <= state_nxt;
                    if (load_main) begin
                        main_q <= in_data;
                    end
                end
            end
        end
    endgenerate

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .clr (rst),
        .inc (stall_inc),
        .cnt (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_drop_cnt (
        .clk (clk),
        .clr (rst),
        .inc (drop_inc),
        .cnt (flush_drop_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: three variants (skid, no-skid, 4-bit counters)
// driven in lockstep and compared every cycle against a FIFO-occupancy model.
module tb_pipe_stage_skid;

    localparam logic [31:0] RST_D = 32'hA5A5_0000;
    localparam logic [31:0] FLS_D = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_data;

    logic        rdy [3];
    logic        vld [3];
    logic [31:0] dat [3];
    logic [15:0] stall0, stall1, drop0, drop1;
    logic [3:0]  stall2, drop2;

    int n_total = 0;
    int n_pass  = 0;
    bit checking = 1'b0;

    // Reference model: a FIFO of depth 1 or 2 plus the value shown when idle.
    int          mcnt  [3];
    logic [31:0] md    [3][2];
    logic [31:0] midle [3];
    int          mstall[3];
    int          mdrop [3];

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(32), .SKID(1), .RESET_DATA(RST_D), .FLUSH_DATA(FLS_D), .CNT_W(16)) u_dut_skid (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy[0]), .in_data(in_data),
        .out_valid(vld[0]), .out_ready(out_ready), .out_data(dat[0]), .stall_cnt(stall0), .flush_drop_cnt(drop0));

    pipe_stage_skid #(.DATA_W(32), .SKID(0), .RESET_DATA(RST_D), .FLUSH_DATA(FLS_D), .CNT_W(16)) u_dut_single (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy[1]), .in_data(in_data),
        .out_valid(vld[1]), .out_ready(out_ready), .out_data(dat[1]), .stall_cnt(stall1), .flush_drop_cnt(drop1));

    pipe_stage_skid #(.DATA_W(32), .SKID(1), .RESET_DATA(RST_D), .FLUSH_DATA(FLS_D), .CNT_W(4)) u_dut_sat (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy[2]), .in_data(in_data),
        .out_valid(vld[2]), .out_ready(out_ready), .out_data(dat[2]), .stall_cnt(stall2), .flush_drop_cnt(drop2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic bit model_ready(input int k);
        if (rst) return 1'b0;
        if (k == 1) return (mcnt[k] == 0) || out_ready;
        return mcnt[k] < 2;
    endfunction

    function automatic logic [31:0] dut_stall(input int k);
        if (k == 0) return {16'b0, stall0};
        if (k == 1) return {16'b0, stall1};
        return {28'b0, stall2};
    endfunction

    function automatic logic [31:0] dut_drop(input int k);
        if (k == 0) return {16'b0, drop0};
        if (k == 1) return {16'b0, drop1};
        return {28'b0, drop2};
    endfunction

    // Inputs are already applied; compare, then advance DUT and model one edge.
    task automatic step();
        bit          r [3];
        bit          v, ifire, ofire;
        int          mx;
        logic [31:0] popped;
        #1;
        for (int k = 0; k < 3; k++) begin
            r[k] = model_ready(k);
            if (checking) begin
                check($sformatf("d%0d_in_ready", k), {31'b0, rdy[k]}, {31'b0, r[k]});
                check($sformatf("d%0d_out_valid", k), {31'b0, vld[k]}, {31'b0, mcnt[k] > 0});
                check($sformatf("d%0d_out_data", k), dat[k], (mcnt[k] > 0) ? md[k][0] : midle[k]);
                check($sformatf("d%0d_stall_cnt", k), dut_stall(k), mstall[k]);
                check($sformatf("d%0d_flush_drop_cnt", k), dut_drop(k), mdrop[k]);
            end
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            mx    = (k == 2) ? 15 : 65535;
            v     = mcnt[k] > 0;
            ifire = in_valid && r[k];
            ofire = v && out_ready;
            if (rst) begin
                mcnt[k] = 0; midle[k] = RST_D; mstall[k] = 0; mdrop[k] = 0;
            end else if (flush) begin
                mdrop[k] = mdrop[k] + mcnt[k] - int'(ofire);
                if (mdrop[k] > mx) mdrop[k] = mx;
                mcnt[k]  = 0;
                midle[k] = FLS_D;
            end else begin
                if (v && !out_ready && mstall[k] < mx) mstall[k]++;
                popped = md[k][0];
                if (ofire) begin
                    md[k][0] = md[k][1];
                    mcnt[k]--;
                end
                if (ifire) begin
                    md[k][mcnt[k]] = in_data;
                    mcnt[k]++;
                end
                if (ofire && mcnt[k] == 0) midle[k] = popped;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        flush = 1'b0; in_valid = 1'b0; in_data = $urandom; out_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_data = $urandom;
            step();
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            mcnt[k] = 0; midle[k] = '0; mstall[k] = 0; mdrop[k] = 0;
            md[k][0] = '0; md[k][1] = '0;
        end
        rst = 1'b1; idle_inputs();
        @(negedge clk);
        step();
        checking = 1'b1;
        do_reset();

        // Streaming with the consumer always ready.
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1'b1; in_data = i;
            step();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("stream_stall_cnt", {16'b0, stall0}, 32'd0);

        // Backpressure: two entries held, then released.
        do_reset();
        in_valid = 1'b1; in_data = 32'hAAAA_0001; step();
        in_data = 32'hBBBB_0002; step();
        in_valid = 1'b0;
        check("bp_full_in_ready", {31'b0, rdy[0]}, 32'd0);
        check("bp_full_head", dat[0], 32'hAAAA_0001);
        for (int i = 0; i < 3; i++) step();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();

        // Flush while full, with a concurrent input that must be dropped.
        do_reset();
        in_valid = 1'b1; in_data = 32'hAAAA_0001; step();
        in_data = 32'hBBBB_0002; step();
        flush = 1'b1; in_data = 32'hCCCC_0003; step();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_valid", {31'b0, vld[0]}, 32'd0);
        check("flush_data", dat[0], FLS_D);
        check("flush_drop_skid", {16'b0, drop0}, 32'd2);
        check("flush_drop_single", {16'b0, drop1}, 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();

        // Stall counter saturation on the 4-bit variant.
        do_reset();
        in_valid = 1'b1; in_data = 32'h1234_5678; step();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) step();
        check("sat_stall_cnt", {28'b0, stall2}, 32'd15);
        step();
        check("sat_stall_hold", {28'b0, stall2}, 32'd15);
        do_reset();

        // Randomised traffic with occasional flush and reset.
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 99) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            in_valid  = ($urandom_range(0, 99) < 65);
            out_ready = ($urandom_range(0, 99) < 60);
            in_data   = $urandom;
            step();
        end
        rst = 1'b0; idle_inputs();
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
